// File: rtl/vga_wr_arbiter_pkg.sv
// Shared constants and types for the VGA framebuffer write arbiter.
// Channel indices name the drawing engines that feed the write port.
package vga_wr_arbiter_pkg;

    localparam int unsigned CH_W       = 3;
    localparam int unsigned DEF_ADDR_W = 19;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned STAT_W     = 16;

    localparam int unsigned CH_MAP    = 0;
    localparam int unsigned CH_NUMBER = 1;
    localparam int unsigned CH_SPRITE = 2;
    localparam int unsigned CH_TEXT   = 3;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/vga_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid channel at or after start, wrapping.
module vga_wr_arbiter_rr_pick #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [IDX_W-1:0] start,
    output logic [N_CH-1:0]  pick,
    output logic             found
);

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (!found && valid[c] && (c == ((int'(start) + k) % int'(N_CH)))) begin
                    pick[c] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_wr_arbiter.sv
// N-channel round-robin write arbiter with burst locking and forced select for the VGA write port.
// Optional per-channel grant counters are built when VGA_WR_ARB_STATS_EN is defined.
module vga_wr_arbiter
    import vga_wr_arbiter_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [N_CH*ADDR_W-1:0] req_addr,
    input  logic [N_CH*DATA_W-1:0] req_data,
    output logic [N_CH-1:0]      req_ready,
    input  logic                 force_en,
    input  logic [CH_W-1:0]      force_sel,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 wr,
    output logic [CH_W-1:0]      wr_ch
`ifdef VGA_WR_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [N_CH*STAT_W-1:0] grant_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t          state_q, state_d;
    logic [CH_W-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_CH-1:0]     grant_c;
    logic [N_CH-1:0]     rr_pick_c;
    logic                rr_found_c;
    logic [CH_W-1:0]     rr_start_c;
    logic [CH_W-1:0]     rr_idx_c;
    logic [CH_W-1:0]     grant_idx_c;
    logic                owner_valid_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_data_c;

    assign rr_start_c = (owner_q == CH_W'(N_CH - 1)) ? '0 : owner_q + CH_W'(1);

    vga_wr_arbiter_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (CH_W)
    ) u_rr_pick (
        .valid (req_valid),
        .start (rr_start_c),
        .pick  (rr_pick_c),
        .found (rr_found_c)
    );

    // Grant decision: force, then continue a locked burst, then round-robin search
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        grant_c       = '0;
        owner_valid_c = 1'b0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (owner_q == CH_W'(c)) owner_valid_c = req_valid[c];
        end
        if (force_en) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (force_sel == CH_W'(c)) grant_c[c] = req_valid[c];
            end
            state_d = ARB_FREE;
        end else if (state_q == ARB_LOCKED && owner_valid_c && cnt_q < CNT_W'(BURST_LEN)) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (owner_q == CH_W'(c)) grant_c[c] = 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rr_found_c) begin
            grant_c = rr_pick_c;
            owner_d = rr_idx_c;
            cnt_d   = CNT_W'(1);
            state_d = ARB_LOCKED;
        end else begin
            state_d = ARB_FREE;
        end
    end

    // One-hot to index and payload mux for the granted channel
    always_comb begin
        rr_idx_c    = '0;
        grant_idx_c = '0;
        sel_addr_c  = '0;
        sel_data_c  = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (rr_pick_c[c]) rr_idx_c = CH_W'(c);
            if (grant_c[c]) begin
                grant_idx_c = CH_W'(c);
                sel_addr_c  = req_addr[c*ADDR_W +: ADDR_W];
                sel_data_c  = req_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = grant_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_FREE;
            owner_q <= CH_W'(N_CH - 1);
            cnt_q   <= '0;
            wr      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_ch   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            wr      <= |grant_c;
            if (|grant_c) begin
                wr_addr <= sel_addr_c;
                wr_data <= sel_data_c;
                wr_ch   <= grant_idx_c;
            end
        end
    end

`ifdef VGA_WR_ARB_STATS_EN
    // Saturating per-channel accepted-transfer counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (stats_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (grant_c[c] && grant_cnt[c*STAT_W +: STAT_W] != {STAT_W{1'b1}})
                    grant_cnt[c*STAT_W +: STAT_W] <= grant_cnt[c*STAT_W +: STAT_W] + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_wr_arbiter.sv
// Self-checking bench for vga_wr_arbiter: two instances (BURST_LEN 8 and 1) share stimulus
// and are compared against a rule-level reference model of the grant decision.
module tb_vga_wr_arbiter;
    import vga_wr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 16;

    logic clk;
    logic rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            force_en;
    logic [2:0]      force_sel;

    logic [N-1:0]  rdy [2];
    logic          wr  [2];
    logic [AW-1:0] wa  [2];
    logic [DW-1:0] wd  [2];
    logic [2:0]    wch [2];
`ifdef VGA_WR_ARB_STATS_EN
    logic             stats_clr;
    logic [N*16-1:0]  gc [2];
    int               m_gc [2][N];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            bl [2] = '{8, 1};
    int            m_owner [2];
    int            m_cnt [2];
    bit            m_lock [2];
    bit            exp_wr [2];
    logic [AW-1:0] exp_addr [2];
    logic [DW-1:0] exp_data [2];
    int            exp_ch [2];
    logic [N-1:0]  obs_rdy [2];

    vga_wr_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy[0]), .force_en(force_en), .force_sel(force_sel),
        .wr_addr(wa[0]), .wr_data(wd[0]), .wr(wr[0]), .wr_ch(wch[0])
`ifdef VGA_WR_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt(gc[0])
`endif
    );

    vga_wr_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(1)) dut_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy[1]), .force_en(force_en), .force_sel(force_sel),
        .wr_addr(wa[1]), .wr_data(wd[1]), .wr(wr[1]), .wr_ch(wch[1])
`ifdef VGA_WR_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt(gc[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit vbit(int i);
        logic [N-1:0] s;
        s = req_valid >> i;
        return s[0];
    endfunction

    // Grant rules: force > continue burst > round-robin from owner+1
    function automatic void model_eval(int b, output int g, output int no, output int nc, output bit nl);
        g  = -1;
        no = m_owner[b];
        nc = m_cnt[b];
        nl = m_lock[b];
        if (force_en) begin
            if (int'(force_sel) < N && vbit(int'(force_sel))) g = int'(force_sel);
            nl = 1'b0;
        end else if (m_lock[b] && vbit(m_owner[b]) && m_cnt[b] < bl[b]) begin
            g  = m_owner[b];
            nc = m_cnt[b] + 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && vbit((m_owner[b] + k) % N)) g = (m_owner[b] + k) % N;
            end
            if (g >= 0) begin
                no = g; nc = 1; nl = 1'b1;
            end else begin
                nl = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_owner[b] = N - 1;
            m_cnt[b]   = 0;
            m_lock[b]  = 1'b0;
            exp_wr[b]  = 1'b0;
`ifdef VGA_WR_ARB_STATS_EN
            for (int c = 0; c < N; c++) m_gc[b][c] = 0;
`endif
        end
    endtask

    task automatic set_addr(int ch, logic [AW-1:0] a);
        req_addr[ch*AW +: AW] = a;
    endtask

    task automatic randomize_payload();
        for (int c = 0; c < N; c++) begin
            req_addr[c*AW +: AW] = AW'($urandom);
            req_data[c*DW +: DW] = DW'($urandom);
        end
    endtask

    // One cycle: inputs already driven after a negedge; returns just after the next negedge
    task automatic step();
        int g [2];
        int no [2];
        int nc [2];
        bit nl [2];
        logic [N-1:0]    e;
        logic [N*AW-1:0] ta;
        logic [N*DW-1:0] td;
        #1;
        for (int b = 0; b < 2; b++) begin
            model_eval(b, g[b], no[b], nc[b], nl[b]);
            e = '0;
            if (g[b] >= 0) e = N'(1) << g[b];
            obs_rdy[b] = rdy[b];
            n_checks++;
            if (rdy[b] !== e) begin
                n_errors++;
                $display("FAIL req_ready inst%0d: got %b expected %b", b, rdy[b], e);
            end
        end
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            m_owner[b] = no[b];
            m_cnt[b]   = nc[b];
            m_lock[b]  = nl[b];
            exp_wr[b]  = (g[b] >= 0);
            if (g[b] >= 0) begin
                ta = req_addr >> (g[b] * AW);
                td = req_data >> (g[b] * DW);
                exp_addr[b] = ta[AW-1:0];
                exp_data[b] = td[DW-1:0];
                exp_ch[b]   = g[b];
            end
`ifdef VGA_WR_ARB_STATS_EN
            if (stats_clr) begin
                for (int c = 0; c < N; c++) m_gc[b][c] = 0;
            end else if (g[b] >= 0 && m_gc[b][g[b]] < 65535) begin
                m_gc[b][g[b]]++;
            end
`endif
        end
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (wr[b] !== exp_wr[b]) begin
                n_errors++;
                $display("FAIL wr inst%0d: got %b expected %b", b, wr[b], exp_wr[b]);
            end
            if (exp_wr[b]) begin
                n_checks++;
                if (wa[b] !== exp_addr[b] || wd[b] !== exp_data[b] || wch[b] !== 3'(exp_ch[b])) begin
                    n_errors++;
                    $display("FAIL wr_payload inst%0d: got ch%0d %h/%h expected ch%0d %h/%h",
                             b, wch[b], wa[b], wd[b], exp_ch[b], exp_addr[b], exp_data[b]);
                end
            end
`ifdef VGA_WR_ARB_STATS_EN
            for (int c = 0; c < N; c++) begin
                n_checks++;
                if (gc[b][c*16 +: 16] !== 16'(m_gc[b][c])) begin
                    n_errors++;
                    $display("FAIL grant_cnt inst%0d ch%0d: got %0d expected %0d",
                             b, c, gc[b][c*16 +: 16], m_gc[b][c]);
                end
            end
`endif
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        force_en  = 1'b0;
        force_sel = '0;
`ifdef VGA_WR_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req_addr = '0;
        req_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (wr[b] !== 1'b0 || wa[b] !== '0 || wd[b] !== '0 || wch[b] !== 3'd0 || rdy[b] !== '0) begin
                n_errors++;
                $display("FAIL reset_state inst%0d: got wr=%b addr=%h data=%h ch=%0d rdy=%b expected all zero",
                         b, wr[b], wa[b], wd[b], wch[b], rdy[b]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        for (int k = 0; k < 5; k++) begin
            randomize_payload();
            req_valid = 4'b0100;
            set_addr(2, AW'(100 + k));
            step();
            n_checks++;
            if (wr[0] !== 1'b1 || wch[0] !== 3'd2 || wa[0] !== AW'(100 + k)) begin
                n_errors++;
                $display("FAIL single beat%0d: got wr=%b ch=%0d addr=%0d expected wr=1 ch=2 addr=%0d",
                         k, wr[0], wch[0], wa[0], 100 + k);
            end
        end
        req_valid = '0;
        step();
        n_checks++;
        if (wr[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL single_idle: got wr=%b expected 0", wr[0]);
        end
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            randomize_payload();
            step();
            n_checks++;
            if (obs_rdy[1] !== (N'(1) << seq[i]) || wr[1] !== 1'b1 || wch[1] !== 3'(seq[i])) begin
                n_errors++;
                $display("FAIL round_robin cycle%0d: got rdy=%b wr=%b ch=%0d expected ch%0d",
                         i, obs_rdy[1], wr[1], wch[1], seq[i]);
            end
        end
    endtask

    task automatic test_burst_lock();
        int e;
        do_reset();
        req_valid = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            randomize_payload();
            step();
            e = (i < 8) ? 0 : ((i < 16) ? 1 : 0);
            n_checks++;
            if (obs_rdy[0] !== (N'(1) << e) || wch[0] !== 3'(e)) begin
                n_errors++;
                $display("FAIL burst_lock cycle%0d: got rdy=%b ch=%0d expected ch%0d", i, obs_rdy[0], wch[0], e);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            randomize_payload();
            step();
            n_checks++;
            if (obs_rdy[0] !== 4'b0001) begin
                n_errors++;
                $display("FAIL early_release beat%0d: got rdy=%b expected 0001", i, obs_rdy[0]);
            end
        end
        req_valid = 4'b1000;
        step();
        n_checks++;
        if (obs_rdy[0] !== 4'b1000 || wr[0] !== 1'b1 || wch[0] !== 3'd3) begin
            n_errors++;
            $display("FAIL early_release_switch: got rdy=%b wr=%b ch=%0d expected rdy=1000 wr=1 ch=3",
                     obs_rdy[0], wr[0], wch[0]);
        end
    endtask

    task automatic test_force();
        force_en  = 1'b1;
        force_sel = 3'd1;
        req_valid = 4'b0011;
        step();
        n_checks++;
        if (obs_rdy[0] !== 4'b0010 || obs_rdy[1] !== 4'b0010 || wch[0] !== 3'd1) begin
            n_errors++;
            $display("FAIL force_grant: got rdy=%b/%b ch=%0d expected 0010 ch1", obs_rdy[0], obs_rdy[1], wch[0]);
        end
        req_valid = 4'b0001;
        step();
        n_checks++;
        if (obs_rdy[0] !== 4'b0000 || wr[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL force_invalid: got rdy=%b wr=%b expected 0000 wr=0", obs_rdy[0], wr[0]);
        end
        force_sel = 3'd5;
        req_valid = 4'b1111;
        step();
        n_checks++;
        if (obs_rdy[0] !== 4'b0000 || obs_rdy[1] !== 4'b0000 || wr[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL force_out_of_range: got rdy=%b/%b wr=%b expected none", obs_rdy[0], obs_rdy[1], wr[1]);
        end
        force_en = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b0100;
        repeat (4) begin
            randomize_payload();
            step();
        end
        rst = 1'b1;
        #1;
        model_reset();
        for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (wr[b] !== 1'b0 || wch[b] !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_mid_burst inst%0d: got wr=%b ch=%0d expected wr=0 ch=0", b, wr[b], wch[b]);
            end
`ifdef VGA_WR_ARB_STATS_EN
            n_checks++;
            if (gc[b] !== '0) begin
                n_errors++;
                $display("FAIL reset_stats inst%0d: got %h expected 0", b, gc[b]);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '1;
        step();
        n_checks++;
        if (obs_rdy[0] !== 4'b0001 || obs_rdy[1] !== 4'b0001) begin
            n_errors++;
            $display("FAIL after_reset_first: got rdy=%b/%b expected 0001", obs_rdy[0], obs_rdy[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) req_valid = N'($urandom);
            force_en  = ($urandom_range(0, 9) == 0);
            force_sel = 3'($urandom_range(0, 7));
`ifdef VGA_WR_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            randomize_payload();
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_early_release();
        test_force();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
